// File: rtl/idli_shift_stage_m.sv
// Operand staging buffer ahead of the single-position shifter: collects 4-bit slices
// into 16-bit entries and replays them with wrapped neighbour bits. Optional flush: IDLI_SSTG_FLUSH_EN.
module idli_shift_stage_m #(
  parameter int NUM_ENTRIES = 2
) (
  input  logic       i_sstg_gck,
  input  logic       i_sstg_rst,
`ifdef IDLI_SSTG_FLUSH_EN
  input  logic       i_sstg_flush,
`endif
  input  logic [3:0] i_sstg_in,
  input  logic       i_sstg_in_vld,
  output logic       o_sstg_in_rdy,
  output logic [3:0] o_sstg_out,
  output logic       o_sstg_out_next,
  output logic       o_sstg_out_prev,
  output logic [1:0] o_sstg_ctr,
  output logic       o_sstg_out_vld,
  input  logic       i_sstg_out_rdy
);

  localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ENTRIES - 1);

  logic [15:0]            entry_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] full_q;
  logic [PTR_W-1:0]       wptr_q;
  logic [PTR_W-1:0]       rptr_q;
  logic [1:0]             wctr_q;
  logic [1:0]             rctr_q;
  logic                   clr;
  logic                   push;
  logic                   pop;
  logic [15:0]            cur;
  logic [1:0]             next_ctr;
  logic [1:0]             prev_ctr;

`ifdef IDLI_SSTG_FLUSH_EN
  assign clr = i_sstg_rst | i_sstg_flush;
`else
  assign clr = i_sstg_rst;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at registered state, so a completing pop never bypasses into a push.
  assign o_sstg_in_rdy  = ~full_q[wptr_q];
  assign o_sstg_out_vld = full_q[rptr_q];
  assign push = i_sstg_in_vld & o_sstg_in_rdy;
  assign pop  = o_sstg_out_vld & i_sstg_out_rdy;

  always_ff @(posedge i_sstg_gck) begin
    if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      wctr_q <= 2'd0;
      rctr_q <= 2'd0;
      full_q <= '0;
    end else begin
      if (push) begin
        wctr_q <= wctr_q + 2'd1;
        if (wctr_q == 2'd3) begin
          full_q[wptr_q] <= 1'b1;
          wptr_q         <= ptr_inc(wptr_q);
        end
      end
      // push targets an empty entry and pop a full one, so the two never collide
      if (pop) begin
        rctr_q <= rctr_q + 2'd1;
        if (rctr_q == 2'd3) begin
          full_q[rptr_q] <= 1'b0;
          rptr_q         <= ptr_inc(rptr_q);
        end
      end
    end
  end

  always_ff @(posedge i_sstg_gck) begin
    if (push && !clr) begin
      entry_q[wptr_q][{wctr_q, 2'b00} +: 4] <= i_sstg_in;
    end
  end

  assign cur             = entry_q[rptr_q];
  assign next_ctr        = rctr_q + 2'd1;
  assign prev_ctr        = rctr_q - 2'd1;
  assign o_sstg_out      = cur[{rctr_q, 2'b00} +: 4];
  assign o_sstg_out_next = cur[{next_ctr, 2'b00}];
  assign o_sstg_out_prev = cur[{prev_ctr, 2'b11}];
  assign o_sstg_ctr      = rctr_q;

endmodule

// File: tb/tb_idli_shift_stage_m.sv
// Scoreboard bench for idli_shift_stage_m (NUM_ENTRIES=2); flush scenario runs when
// IDLI_SSTG_FLUSH_EN is defined.
module tb_idli_shift_stage_m;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_vld = 1'b0;
  logic       in_rdy;
  logic [3:0] out_data;
  logic       out_next;
  logic       out_prev;
  logic [1:0] ctr;
  logic       out_vld;
  logic       out_rdy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb[$];
  int  cyc = 0;
  int  last_pop_cyc = -10;
  int  bubbles = 0;
  int  stall_cnt = 0;
  int  acc_cnt = 0;
  logic       hold_prev = 1'b0;
  logic       dist_prev = 1'b1;
  logic [7:0] held = 8'd0;
  logic       stall_prev = 1'b0;
  logic [3:0] in_prev = 4'd0;
  logic       done3 = 1'b0;

  idli_shift_stage_m #(.NUM_ENTRIES(2)) dut (
    .i_sstg_gck      (clk),
    .i_sstg_rst      (rst),
`ifdef IDLI_SSTG_FLUSH_EN
    .i_sstg_flush    (flush),
`endif
    .i_sstg_in       (in_data),
    .i_sstg_in_vld   (in_vld),
    .o_sstg_in_rdy   (in_rdy),
    .o_sstg_out      (out_data),
    .o_sstg_out_next (out_next),
    .o_sstg_out_prev (out_prev),
    .o_sstg_ctr      (ctr),
    .o_sstg_out_vld  (out_vld),
    .i_sstg_out_rdy  (out_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected replay word {ctr, slice, next bit, prev bit} for slice s of operand v.
  function automatic logic [7:0] exp_slice(input logic [15:0] v, input int s);
    return {2'(s), v[4*s +: 4], v[4*((s+1)%4)], v[4*((s+3)%4)+3]};
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (hold_prev && !dist_prev) begin
      check("hold_vld", 32'(out_vld), 32'd1);
      check("hold_data", 32'({ctr, out_data, out_next, out_prev}), 32'(held));
    end
    if (!rst && !flush && out_vld && out_rdy) begin
      if (last_pop_cyc != cyc - 1) bubbles++;
      last_pop_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'({ctr, out_data, out_next, out_prev}), 32'hFFFF);
      end else begin
        check("replay", 32'({ctr, out_data, out_next, out_prev}), 32'(sb.pop_front()));
      end
    end
    if (!rst && in_vld && !in_rdy) stall_cnt++;
    if (!rst && !flush && in_vld && in_rdy) acc_cnt++;
    hold_prev = out_vld && !out_rdy;
    held      = {ctr, out_data, out_next, out_prev};
    dist_prev = rst | flush;
  end

  // Upstream must hold its slice steady while stalled.
  always @(negedge clk) begin
    if (stall_prev && in_vld && !rst)
      assert (in_data == in_prev) else $error("upstream slice changed while stalled");
    stall_prev = in_vld && !in_rdy;
    in_prev    = in_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_slice(input logic [3:0] d);
    int n = 0;
    in_data = d;
    in_vld  = 1'b1;
    while (!in_rdy && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("push_timeout", 32'(in_rdy), 32'd1);
    step();
  endtask

  task automatic push_op(input logic [15:0] v);
    for (int s = 0; s < 4; s++) sb.push_back(exp_slice(v, s));
    for (int s = 0; s < 4; s++) push_slice(v[4*s +: 4]);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    repeat (3) step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_ctr", 32'(ctr), 32'd0);
    out_rdy = 1'b1;
    step();
    step();
    out_rdy = 1'b0;
    step();
    check("idle_in_rdy", 32'(in_rdy), 32'd1);
    check("idle_out_vld", 32'(out_vld), 32'd0);
    check("idle_ctr", 32'(ctr), 32'd0);

    // Single operand, slice 0 valid the cycle after slice 3 is pushed
    out_rdy = 1'b1;
    push_op(16'h8001);
    in_vld = 1'b0;
    check("latency_vld", 32'(out_vld), 32'd1);
    check("latency_ctr", 32'(ctr), 32'd0);
    drain("drain_8001");

    // Back-to-back operands at full rate
    bubbles = 0;
    stall_cnt = 0;
    push_op(16'h1234);
    push_op(16'hABCD);
    in_vld = 1'b0;
    drain("drain_b2b");
    check("b2b_bubbles", 32'(bubbles), 32'd1);
    check("b2b_stalls", 32'(stall_cnt), 32'd0);

    // Back-pressure: three operands into two entries
    out_rdy = 1'b0;
    acc_cnt = 0;
    done3 = 1'b0;
    fork
      begin
        push_op(16'h1234);
        push_op(16'hABCD);
        push_op(16'h5E6F);
        in_vld = 1'b0;
        done3 = 1'b1;
      end
    join_none
    repeat (12) step();
    check("full_acc", 32'(acc_cnt), 32'd8);
    check("full_in_rdy", 32'(in_rdy), 32'd0);
    check("full_out_vld", 32'(out_vld), 32'd1);
    check("full_out", 32'(out_data), 32'h4);
    check("full_ctr", 32'(ctr), 32'd0);
    out_rdy = 1'b1;
    repeat (4) step();
    out_rdy = 1'b0;
    check("freed_in_rdy", 32'(in_rdy), 32'd1);
    out_rdy = 1'b1;
    for (int n = 0; n < 300 && !done3; n++) step();
    check("third_done", 32'(done3), 32'd1);
    drain("drain_bp");

    // Reset in the middle of an operand
    push_slice(4'h4);
    push_slice(4'h3);
    in_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_out_vld", 32'(out_vld), 32'd0);
    check("mid_rst_in_rdy", 32'(in_rdy), 32'd1);
    check("mid_rst_ctr", 32'(ctr), 32'd0);
    push_op(16'h00F0);
    in_vld = 1'b0;
    drain("drain_00f0");

`ifdef IDLI_SSTG_FLUSH_EN
    out_rdy = 1'b0;
    push_op(16'h1357);
    push_op(16'h2468);
    in_vld = 1'b0;
    out_rdy = 1'b1;
    repeat (2) step();
    check("pre_flush_ctr", 32'(ctr), 32'd2);
    out_rdy = 1'b0;
    flush = 1'b1;
    sb.delete();
    step();
    flush = 1'b0;
    check("flush_out_vld", 32'(out_vld), 32'd0);
    check("flush_in_rdy", 32'(in_rdy), 32'd1);
    check("flush_ctr", 32'(ctr), 32'd0);
    out_rdy = 1'b1;
    push_op(16'h9ACE);
    in_vld = 1'b0;
    drain("drain_flush");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/idli_shift_stage_m.md
Name: idli_shift_stage_m

Overview:
- Operand staging buffer directly upstream of the single-position shifter.
- Collects a 16-bit operand arriving as four 4-bit slices, LSB slice first.
- Replays the operand slice by slice together with the slice counter and the neighbour bits the shifter needs:
  - LSB of the next slice.
  - MSB of the previous slice.
  - Both wrap within the operand, so rotates see the operand's own bits.
- Multi-entry so capture of operand N+1 overlaps replay of operand N.

Parameters:
- NUM_ENTRIES, 2, number of 16-bit operand entries; legal values 1, 2, 4.

Ports:
- i_sstg_gck, input, 1, clock.
- i_sstg_rst, input, 1, synchronous active-high reset.
- i_sstg_in, input, slice_t (4), incoming operand slice.
- i_sstg_in_vld, input, 1, incoming slice valid.
- o_sstg_in_rdy, output, 1, buffer can accept a slice.
- o_sstg_out, output, slice_t (4), current replay slice to shifter.
- o_sstg_out_next, output, 1, bit 0 of the following slice (wraps).
- o_sstg_out_prev, output, 1, bit 3 of the preceding slice (wraps).
- o_sstg_ctr, output, ctr_t (2), index of the slice on o_sstg_out.
- o_sstg_out_vld, output, 1, replay slice valid.
- i_sstg_out_rdy, input, 1, shifter consumes the slice this cycle.

Behaviour:
- Reset (sync, active-high, dominates everything):
  - Write/read pointers, write/read slice counters and all entry-full flags clear.
  - o_sstg_out_vld=0, o_sstg_in_rdy=1, o_sstg_ctr=0.
  - Entry data is not reset. o_sstg_out, o_sstg_out_next and o_sstg_out_prev are only checked when o_sstg_out_vld=1.
- Write side:
  - Push = i_sstg_in_vld & o_sstg_in_rdy.
  - Push stores i_sstg_in into entry[wptr] slice[wctr], then wctr increments mod 4.
  - Push with wctr==3 sets full[wptr] and advances wptr mod NUM_ENTRIES.
  - o_sstg_in_rdy = ~full[wptr], driven from registered state only (no combinational path from i_sstg_out_rdy).
  - A partly written entry is never visible to the read side.
- Read side:
  - o_sstg_out_vld = full[rptr].
  - o_sstg_out = entry[rptr] slice[rctr]; o_sstg_ctr = rctr.
  - o_sstg_out_next = entry[rptr] bit 4*((rctr+1) mod 4).
  - o_sstg_out_prev = entry[rptr] bit 4*((rctr+3) mod 4)+3.
  - Pop = o_sstg_out_vld & i_sstg_out_rdy; pop increments rctr mod 4.
  - Pop with rctr==3 clears full[rptr] and advances rptr.
- Latency:
  - Slice 0 of an operand is valid the cycle after its slice 3 is pushed.
  - Full-rate replay takes 4 consecutive cycles.
- Handshake:
  - Once o_sstg_out_vld=1, outputs stay stable until the pop.
  - Upstream must hold i_sstg_in stable while i_sstg_in_vld & ~o_sstg_in_rdy. A bench assertion checks this.
- Simultaneous events:
  - Completing pop (rctr==3) and completing push in the same cycle update different entries. Both take effect.
  - When NUM_ENTRIES=1, o_sstg_in_rdy stays 0 during the completing-pop cycle. The push occurs one cycle later (no bypass).
- Full: all entries full → o_sstg_in_rdy=0 until a completing pop.
- Empty: o_sstg_out_vld=0; i_sstg_out_rdy is ignored.
- Wrap-around: pointers wrap at NUM_ENTRIES. Counters wrap at 4.
- Reset mid-operand discards partial writes and partial replays. Operation restarts from slice 0 on both sides.

Optional Feature:
- Macro: IDLI_SSTG_FLUSH_EN.
- With the macro:
  - Adds input i_sstg_flush (1).
  - Flush has the same effect as reset on pointers, counters and full flags.
  - Flush overrides push/pop in the same cycle; reset overrides flush.
  - In the cycle after flush: o_sstg_out_vld=0, o_sstg_in_rdy=1.
- Without the macro: the port is absent and no flush logic is generated.

Test Plan:
- Reset then idle:
  - Expect o_sstg_in_rdy=1, o_sstg_out_vld=0, o_sstg_ctr=0.
  - Pulsing i_sstg_out_rdy changes nothing.
- Push 0x8001 as slices 1,0,0,8 with out_rdy=1:
  - ctr0: out=1, next=0, prev=1.
  - ctr1: out=0, next=0, prev=0.
  - ctr2: out=0, next=0, prev=0.
  - ctr3: out=8, next=1, prev=0.
  - Slice 0 is valid 1 cycle after slice 3 is pushed.
- NUM_ENTRIES=2, back-to-back 0x1234 and 0xABCD:
  - Continuous push of 8 slices with out_rdy=1.
  - Expect out sequence 4,3,2,1,D,C,B,A with no bubbles after the first.
  - in_rdy stays 1 throughout.
- Hold out_rdy=0 while pushing 3 operands (NUM_ENTRIES=2):
  - in_rdy drops after 8 slices are accepted.
  - Outputs hold slice 4 (of 0x1234) stable.
  - in_rdy returns after 4 pops.
  - Third operand data arrives intact.
- Reset asserted after 2 slices of 0x1234:
  - Next cycle: out_vld=0.
  - Pushing 0x00F0 afterwards replays 0,F,0,0.
- IDLI_SSTG_FLUSH_EN defined:
  - Flush while replaying at ctr2 with a second entry full.
  - Next cycle: out_vld=0, in_rdy=1.
  - The next operand replays from ctr0.
